fb_scanout_ctrl: RTL and testbench

//  Video scan-out sequencer for the data memory's read-only video port (vaddr -> registered vdata, 1 clk).

---
 rtl/fb_scanout_if.sv | 30 +++
 rtl/fb_scanout_ctrl.sv | 169 ++++++++++++++++
 tb/tb_fb_scanout_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fb_scanout_if.sv
// Scan-out bundle: byte-address read port into dmem plus the timed pixel/sync outputs.
interface fb_scanout_if;
  logic [31:0] vaddr;
  logic [31:0] vdata;
  logic [7:0]  pixel;
  logic        de;
  logic        hsync;
  logic        vsync;
  logic        frame_start;

  modport master (
    output vaddr,
    input  vdata,
    output pixel,
    output de,
    output hsync,
    output vsync,
    output frame_start
  );

  modport slave (
    input  vaddr,
    output vdata,
    input  pixel,
    input  de,
    input  hsync,
    input  vsync,
    input  frame_start
  );
endinterface

// File: rtl/fb_scanout_ctrl.sv
// VGA-style scan-out sequencer: h/v timing, per-pixel byte fetch from a byte-packed
// frame buffer, and pixel/de/sync outputs aligned two pixel ticks after the counters.
module fb_scanout_ctrl #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned FB_W       = 80,
  parameter int unsigned SCALE_LOG2 = 3,
  parameter bit          SYNC_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        enable,
  input  logic [31:0] fb_base,
  output logic        busy,
  fb_scanout_if.master vid
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW = $clog2(H_TOTAL);
  localparam int unsigned VW = $clog2(V_TOTAL);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [31:0]   base_q, base_d;
  logic          frame_start_q, frame_start_d;

  always_comb begin
    state_d       = state_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    base_d        = base_q;
    frame_start_d = frame_start_q;
    if (pix_en) begin
      frame_start_d = 1'b0;
      unique case (state_q)
        StIdle: begin
          h_cnt_d = '0;
          v_cnt_d = '0;
          if (enable) begin
            state_d       = StRun;
            base_d        = fb_base;
            frame_start_d = 1'b1;
          end
        end
        StRun: begin
          if (h_cnt_q == HW'(H_TOTAL - 1)) begin
            h_cnt_d = '0;
            if (v_cnt_q == VW'(V_TOTAL - 1)) begin
              v_cnt_d = '0;
              if (enable) begin
                base_d        = fb_base;
                frame_start_d = 1'b1;
              end else begin
                state_d = StIdle;
              end
            end else begin
              v_cnt_d = v_cnt_q + VW'(1);
            end
          end else begin
            h_cnt_d = h_cnt_q + HW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Stage A decode; compared in 32 bits so bounds equal to a power of two cannot truncate.
  logic        run_a, vis_a, hs_a, vs_a;
  logic [31:0] h_a, v_a, addr_a;

  always_comb begin
    h_a    = 32'(h_cnt_q);
    v_a    = 32'(v_cnt_q);
    run_a  = (state_q == StRun);
    vis_a  = run_a && (h_a < H_ACTIVE) && (v_a < V_ACTIVE);
    hs_a   = run_a && (h_a >= H_ACTIVE + H_FP) && (h_a < H_ACTIVE + H_FP + H_SYNC);
    vs_a   = run_a && (v_a >= V_ACTIVE + V_FP) && (v_a < V_ACTIVE + V_FP + V_SYNC);
    addr_a = base_q + (v_a >> SCALE_LOG2) * FB_W + (h_a >> SCALE_LOG2);
  end

  logic [31:0] vaddr_q, data2_q;
  logic [1:0]  lane2_q;
  logic        vis1_q, hs1_q, vs1_q, vis2_q, hs2_q, vs2_q;
  logic        pix_en_d_q, late_q;
  logic [7:0]  pixel_q;
  logic        de_q, hsync_q, vsync_q;
  logic [31:0] word_sel;
  logic [7:0]  byte_sel;

  // Back-to-back ticks leave no clk for dmem to answer before stage 2 samples, so the
  // word is taken live at the output tick (late_q) or caught on the next idle clk.
  always_comb begin
    word_sel = late_q ? vid.vdata : data2_q;
    byte_sel = word_sel[7:0];
    unique case (lane2_q)
      2'd0: byte_sel = word_sel[7:0];
      2'd1: byte_sel = word_sel[15:8];
      2'd2: byte_sel = word_sel[23:16];
      2'd3: byte_sel = word_sel[31:24];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      base_q        <= '0;
      frame_start_q <= 1'b0;
      vaddr_q       <= '0;
      data2_q       <= '0;
      lane2_q       <= '0;
      {vis1_q, hs1_q, vs1_q, vis2_q, hs2_q, vs2_q} <= '0;
      pix_en_d_q    <= 1'b0;
      late_q        <= 1'b0;
      pixel_q       <= '0;
      de_q          <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      base_q        <= base_d;
      frame_start_q <= frame_start_d;
      pix_en_d_q    <= pix_en;
      if (pix_en) begin
        if (vis_a) vaddr_q <= addr_a;
        vis1_q  <= vis_a;
        hs1_q   <= hs_a;
        vs1_q   <= vs_a;
        vis2_q  <= vis1_q;
        hs2_q   <= hs1_q;
        vs2_q   <= vs1_q;
        lane2_q <= vaddr_q[1:0];
        data2_q <= vid.vdata;
        late_q  <= pix_en_d_q;
        pixel_q <= vis2_q ? byte_sel : 8'h00;
        de_q    <= vis2_q;
        hsync_q <= hs2_q ? SYNC_POL : ~SYNC_POL;
        vsync_q <= vs2_q ? SYNC_POL : ~SYNC_POL;
      end else if (late_q) begin
        data2_q <= vid.vdata;
        late_q  <= 1'b0;
      end
    end
  end

  assign vid.vaddr       = vaddr_q;
  assign vid.pixel       = pixel_q;
  assign vid.de          = de_q;
  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.frame_start = frame_start_q;
  assign busy            = (state_q == StRun);

endmodule

// File: tb/tb_fb_scanout_ctrl.sv
// Randomized bench for fb_scanout_ctrl: small timing, registered dmem model, and a
// frame-index reference model predicting every output on every clk.
module tb_fb_scanout_ctrl;

  localparam int unsigned HA = 32, HF = 4, HS = 6, HB = 6;
  localparam int unsigned VA = 24, VF = 2, VS = 2, VB = 3;
  localparam int unsigned FBW = 6, SL = 3;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;
  localparam int unsigned FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        reset, pix_en, enable, busy;
  logic [31:0] fb_base;

  fb_scanout_if vid ();

  fb_scanout_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .FB_W(FBW), .SCALE_LOG2(SL), .SYNC_POL(1'b0)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .pix_en (pix_en),
    .enable (enable),
    .fb_base(fb_base),
    .busy   (busy),
    .vid    (vid.master)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [2048];
  always @(posedge clk) vid.vdata <= mem[vid.vaddr[12:2]];

  int unsigned checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] fb_byte(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[12:2]];
    return w[8*a[1:0] +: 8];
  endfunction

  // Reference: position is a tick index within the frame; expected pins trail it by 2 ticks.
  typedef struct packed {
    logic [7:0] pix;
    logic       de;
    logic       hs;
    logic       vs;
  } pins_t;

  bit          m_run = 1'b0;
  int unsigned m_idx = 0, m_frames = 0;
  logic [31:0] m_base = '0, m_vaddr = '0;
  logic        m_fs = 1'b0;
  pins_t       d1 = '0, d2 = '0, pe = '0;

  task automatic model_edge();
    pins_t       t;
    int unsigned x, y;
    logic [31:0] a;
    if (reset) begin
      m_run = 1'b0; m_idx = 0; m_vaddr = '0; m_fs = 1'b0;
      d1 = '0; d2 = '0; pe = '0;
    end else if (pix_en) begin
      t = '0;
      m_fs = 1'b0;
      if (m_run) begin
        x = m_idx % HT;
        y = m_idx / HT;
        t.hs = (x >= HA + HF) && (x < HA + HF + HS);
        t.vs = (y >= VA + VF) && (y < VA + VF + VS);
        if (x < HA && y < VA) begin
          a = m_base + (y >> SL) * FBW + (x >> SL);
          t.de = 1'b1;
          t.pix = fb_byte(a);
          m_vaddr = a;
        end
        m_idx++;
        if (m_idx == FRAME) begin
          m_idx = 0;
          if (enable) begin
            m_base = fb_base; m_fs = 1'b1; m_frames++;
          end else begin
            m_run = 1'b0;
          end
        end
      end else if (enable) begin
        m_run = 1'b1; m_idx = 0; m_base = fb_base; m_fs = 1'b1; m_frames++;
      end
      pe = d2;
      d2 = d1;
      d1 = t;
    end
  endtask

  task automatic check_pins();
    check("pixel", 32'(vid.pixel), 32'(pe.pix));
    check("de", 32'(vid.de), 32'(pe.de));
    check("hsync", 32'(vid.hsync), 32'(!pe.hs));
    check("vsync", 32'(vid.vsync), 32'(!pe.vs));
    check("frame_start", 32'(vid.frame_start), 32'(m_fs));
    check("busy", 32'(busy), 32'(m_run));
    check("vaddr", vid.vaddr, m_vaddr);
  endtask

  int unsigned clk_n = 0;
  int          mode = 0;

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_pins();
    clk_n++;
    case (mode)
      0:       pix_en = 1'b1;
      1:       pix_en = (clk_n % 3 == 0);
      default: pix_en = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic wait_frames(input int unsigned n);
    int unsigned tgt;
    tgt = m_frames + n;
    for (int i = 0; i < 30000 && m_frames < tgt; i++) cycle();
    check("wait_frames_timeout", m_frames, tgt);
  endtask

  task automatic wait_line(input int unsigned line);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 30000 && !hit; i++) begin
      cycle();
      hit = m_run && (m_idx == line * HT);
    end
    check("wait_line_timeout", 32'(hit), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30000 && m_run; i++) cycle();
    check("wait_idle_timeout", 32'(m_run), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = $urandom;
    mem[0] = 32'h4433_2211;
    mem[1] = 32'hAABB_CCDD;
    reset = 1'b1; pix_en = 1'b1; enable = 1'b0; fb_base = '0; mode = 0;
    repeat (3) cycle();
    reset = 1'b0;
    repeat (100) cycle();

    // Full-rate scan from base 0; base change mid-frame lands only at the next frame.
    enable = 1'b1;
    wait_line(10);
    fb_base = 32'h1000;
    wait_frames(1);
    wait_line(5);
    enable = 1'b0;
    wait_idle();
    repeat (200) cycle();

    // One tick every third clk, unaligned base, then reset mid-frame and restart.
    mode = 1;
    fb_base = $urandom_range(0, 32'h1FE0);
    enable = 1'b1;
    wait_frames(2);
    wait_line(12);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    fb_base = $urandom_range(0, 32'h1FE0);
    wait_frames(1);

    // Irregular tick spacing including back-to-back ticks.
    mode = 2;
    wait_line(3);
    fb_base = $urandom_range(0, 32'h1FE0);
    repeat (3000) cycle();
    enable = 1'b0;
    wait_idle();
    repeat (50) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
